// File: rtl/pcie_trans_pkg.sv
// Shared state encoding, field-position helpers and threshold clamping for
// the parametrised PCIe transaction virtual-channel path.
package pcie_trans_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam int UMBRAL_LO_RST = 1;
    localparam int UMBRAL_HI_RST = 2;

    // The VC field sits at the top of the word, with the dest field just below it.
    function automatic int vc_field_msb(input int dw);
        return dw - 1;
    endfunction

    function automatic int dest_field_msb(input int dw, input int vcb);
        return dw - 1 - vcb;
    endfunction

    function automatic int clamp_umbral(input int umbral, input int depth);
        return (umbral > depth) ? depth : umbral;
    endfunction

endpackage

// File: rtl/pcie_sync_fifo.sv
// Synchronous FIFO with count-derived full/empty, programmable almost
// thresholds and an overflow strobe for a push that cannot be stored.
module pcie_sync_fifo #(
    parameter  int DW    = 6,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    input  logic [CW-1:0] umbral_lo,
    input  logic [CW-1:0] umbral_hi,
    output logic [DW-1:0] dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= (DEPTH_C - umbral_hi));
    assign almost_empty = (count <= umbral_lo);
    assign do_pop       = pop && !empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign do_push      = push && (!full || do_pop);
    assign overflow     = push && full && !do_pop;
    assign dout         = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pcie_trans_vc.sv
// Main FIFO feeding per-VC FIFOs, with an arbiter that drains the VC heads
// onto per-destination output registers under a small control FSM.
module pcie_trans_vc
    import pcie_trans_pkg::*;
#(
    parameter int DW       = 6,
    parameter int NUM_VC   = 2,
    parameter int NUM_DEST = 2,
    parameter int MF_DEPTH = 4,
    parameter int VC_DEPTH = 16,
    parameter int ARB_MODE = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init,
    input  logic [$clog2(VC_DEPTH)-1:0]  umbral_lo,
    input  logic [$clog2(VC_DEPTH)-1:0]  umbral_hi,
    input  logic                         push,
    input  logic [DW-1:0]                data_in,
    input  logic [NUM_DEST-1:0]          dest_pause,
    output logic                         pause_out,
    output logic [NUM_DEST*DW-1:0]       data_out,
    output logic [NUM_DEST-1:0]          valid_out,
    output logic                         active_out,
    output logic                         idle_out,
    output logic                         error_out,
    output logic [NUM_VC:0]              error_id
);

    localparam int VCB      = $clog2(NUM_VC);
    localparam int DSB      = $clog2(NUM_DEST);
    localparam int UW       = $clog2(VC_DEPTH);
    localparam int MCW      = $clog2(MF_DEPTH) + 1;
    localparam int VCW      = $clog2(VC_DEPTH) + 1;
    localparam int VC_MSB   = vc_field_msb(DW);
    localparam int DEST_MSB = dest_field_msb(DW, VCB);

    state_t state;
    state_t next_state;

    logic          run;
    logic          push_en;
    logic          overflow;
    logic          any_data;
    logic [UW-1:0] lo_q;
    logic [UW-1:0] hi_q;
    logic [MCW-1:0] mf_lo;
    logic [MCW-1:0] mf_hi;
    logic [VCW-1:0] vc_lo;
    logic [VCW-1:0] vc_hi;

    logic           mf_pop;
    logic           mf_full;
    logic           mf_empty;
    logic           mf_af;
    logic           mf_ae_unused;
    logic           mf_ovf;
    logic [DW-1:0]  mf_dout;
    logic [MCW-1:0] mf_count_unused;
    logic [VCB-1:0] head_vc;

    logic [NUM_VC-1:0] vc_push;
    logic [NUM_VC-1:0] vc_pop;
    logic [NUM_VC-1:0] vc_empty;
    logic [NUM_VC-1:0] vc_af;
    logic [NUM_VC-1:0] vc_full_unused;
    logic [NUM_VC-1:0] vc_ae_unused;
    logic [NUM_VC-1:0] vc_ovf;
    logic [NUM_VC-1:0] eligible;
    logic [DW-1:0]     vc_dout [NUM_VC];
    logic [DSB-1:0]    vc_dest [NUM_VC];

    logic           found;
    logic [VCB-1:0] idx;
    logic [VCB-1:0] grant_idx;
    logic [VCB-1:0] rr_ptr;
    logic [DSB-1:0] grant_dest;

    logic [NUM_DEST-1:0]    valid_q;
    logic [NUM_DEST*DW-1:0] data_q;

    assign run      = (state == ST_IDLE) || (state == ST_ACTIVE);
    assign push_en  = push && (state != ST_ERROR);
    assign overflow = mf_ovf || (|vc_ovf);
    assign any_data = !mf_empty || !(&vc_empty);

    // Thresholds are shared by every FIFO, each clamped to that FIFO's own depth.
    assign mf_lo = MCW'(clamp_umbral(32'(lo_q), MF_DEPTH));
    assign mf_hi = MCW'(clamp_umbral(32'(hi_q), MF_DEPTH));
    assign vc_lo = VCW'(clamp_umbral(32'(lo_q), VC_DEPTH));
    assign vc_hi = VCW'(clamp_umbral(32'(hi_q), VC_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            lo_q <= UW'(UMBRAL_LO_RST);
            hi_q <= UW'(UMBRAL_HI_RST);
        end else if (init) begin
            lo_q <= umbral_lo;
            hi_q <= umbral_hi;
        end
    end

    assign head_vc = mf_dout[VC_MSB -: VCB];
    assign mf_pop  = run && !mf_empty && !vc_af[head_vc];

    pcie_sync_fifo #(.DW(DW), .DEPTH(MF_DEPTH)) u_main_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push_en),
        .pop          (mf_pop),
        .din          (data_in),
        .umbral_lo    (mf_lo),
        .umbral_hi    (mf_hi),
        .dout         (mf_dout),
        .count        (mf_count_unused),
        .full         (mf_full),
        .empty        (mf_empty),
        .almost_full  (mf_af),
        .almost_empty (mf_ae_unused),
        .overflow     (mf_ovf)
    );

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic [VCW-1:0] count_unused;

        assign vc_push[v]  = mf_pop && (head_vc == VCB'(v));
        assign vc_dest[v]  = vc_dout[v][DEST_MSB -: DSB];
        assign eligible[v] = run && !vc_empty[v] && !dest_pause[vc_dest[v]];

        pcie_sync_fifo #(.DW(DW), .DEPTH(VC_DEPTH)) u_vc_fifo (
            .clk          (clk),
            .reset        (reset),
            .push         (vc_push[v]),
            .pop          (vc_pop[v]),
            .din          (mf_dout),
            .umbral_lo    (vc_lo),
            .umbral_hi    (vc_hi),
            .dout         (vc_dout[v]),
            .count        (count_unused),
            .full         (vc_full_unused[v]),
            .empty        (vc_empty[v]),
            .almost_full  (vc_af[v]),
            .almost_empty (vc_ae_unused[v]),
            .overflow     (vc_ovf[v])
        );
    end

    // Round robin scans from the VC after the last grant; strict mode scans from VC 0.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            idx = (ARB_MODE == 1) ? rr_ptr + VCB'(i + 1) : VCB'(i);
            if (!found && eligible[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        vc_pop = '0;
        if (found) vc_pop[grant_idx] = 1'b1;
    end

    assign grant_dest = vc_dest[grant_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= VCB'(NUM_VC - 1);
        end else if (found) begin
            rr_ptr <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= '0;
            if (found) begin
                valid_q[grant_dest]            <= 1'b1;
                data_q[grant_dest*DW +: DW]    <= vc_dout[grant_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pause_out <= 1'b0;
            error_id  <= '0;
        end else begin
            pause_out <= mf_af;
            error_id  <= error_id | {vc_ovf, mf_ovf};
        end
    end

    assign data_out  = data_q;
    assign valid_out = (state == ST_ERROR) ? '0 : valid_q;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RESET;
        else       state <= next_state;
    end

    // An overflow outranks init in every state that can see traffic.
    always_comb begin
        next_state = state;
        case (state)
            ST_RESET:  next_state = ST_INIT;
            ST_INIT: begin
                if (overflow)   next_state = ST_ERROR;
                else if (!init) next_state = ST_IDLE;
            end
            ST_IDLE: begin
                if (overflow)      next_state = ST_ERROR;
                else if (init)     next_state = ST_INIT;
                else if (any_data) next_state = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (overflow)       next_state = ST_ERROR;
                else if (init)      next_state = ST_INIT;
                else if (!any_data) next_state = ST_IDLE;
            end
            ST_ERROR:  next_state = ST_ERROR;
            default:   next_state = ST_RESET;
        endcase
    end

    always_comb begin
        active_out = 1'b0;
        idle_out   = 1'b0;
        error_out  = 1'b0;
        case (state)
            ST_IDLE:   idle_out   = 1'b1;
            ST_ACTIVE: active_out = 1'b1;
            ST_ERROR:  error_out  = 1'b1;
            default:   ;
        endcase
    end

endmodule
